dcache_victim_ctrl: RTL and testbench
=====================================

// Module: dcache_victim_ctrl
// PURPOSE
// - Per-set replacement/refill controller for the 4-way cache; consumes the tag-compare result (hit, hit way).
// - Owns per-set PLRU, valid and dirty state; drives the combinational plru sub-module.
// - On miss: picks the victim, runs dirty writeback then refill over two req/ack/done channels, reports the filled way.
// PARAMETERS
// - ASSOCIATIVITY  4   ways per set; only 4 is legal (3-bit tree PLRU)
// - SET_NUM        64  sets; power of two; SET_BITS = $clog2(SET_NUM)
// PORTS
// - clk          in   1         clock; all state on rising edge
// - resetn       in   1         asynchronous, active-low reset
// - acc_valid    in   1         lookup result valid this cycle
// - acc_set      in   SET_BITS  set index of the access
// - acc_hit      in   1         tag hit
// - acc_hit_way  in   2         hit way (meaningful when acc_hit)
// - acc_write    in   1         access is a store
// - acc_ready    out  1         high only in IDLE; access consumed when acc_valid&&acc_ready
// - miss_done    out  1         one-cycle pulse: refill complete
// - miss_way     out  2         way filled (valid with miss_done)
// - wb_req       out  1         writeback request; held until wb_ack
// - wb_set       out  SET_BITS  writeback set; stable while wb_req
// - wb_way       out  2         writeback way; stable while wb_req
// - wb_ack       in   1         writeback request accepted
// - wb_done      in   1         writeback data fully transferred
// - rf_req / rf_set / rf_way    out  1/SET_BITS/2  refill request, same rules as wb_*
// - rf_ack       in   1         refill request accepted
// - rf_done      in   1         refill line written into data array
// BEHAVIOUR
// - Reset: state IDLE; plru/valid/dirty arrays all 0; acc_ready=1; wb_req=rf_req=miss_done=0; set/way outputs 0.
// - PLRU per set, bits p[2:0]: victim[1]=p[2]; victim[0]=p[2]?p[0]:p[1].
//   Touch way w: p[2]=~w[1]; if w[1] p[0]=~w[0] else p[1]=~w[0].
// - Hit (IDLE, acc_valid&&acc_hit): next edge touches PLRU[acc_set] with acc_hit_way; acc_write sets dirty.
//   No stall; back-to-back hits to one set see the previous update (write-first bypass).
// - Miss (IDLE, acc_valid&&!acc_hit): latch set and write flag.
//   Victim = lowest-index invalid way; if none, PLRU victim from the bypassed PLRU[set].
//   Next state: WB_REQ if victim valid&&dirty, else RF_REQ.
// - FSM: IDLE -> WB_REQ -> WB_WAIT -> RF_REQ -> RF_WAIT -> DONE -> IDLE.
//   WB_REQ: wb_req=1 until wb_ack, then WB_WAIT.
//   WB_WAIT: on wb_done clear dirty[set][victim] and valid, then RF_REQ.
//   RF_REQ/RF_WAIT: same handshake on rf_*.
//   On rf_done: valid=1, dirty=latched write flag, touch PLRU with victim; go to DONE.
//   DONE: miss_done=1 and miss_way=victim for exactly one cycle; acc_ready=0.
// - Protocol: *_done is honoured only in *_WAIT; it arrives no earlier than the cycle after *_ack.
//   acc_* is ignored whenever acc_ready=0; miss latency >= 4 cycles.
// - resetn low mid-miss: immediate return to reset state; requests drop asynchronously; the in-flight line is lost.
// STRUCTURE
// - Shared cache package: set_t, way_t (logic[1:0]), plru_t (logic[2:0]), victim_state_t enum.
// - One sub-module: instantiate combinational plru (ASSOCIATIVITY=4) for victim select and touch.
//   PLRU muxed from hit way (hit) or victim (refill).
// - State arrays are flops (SET_NUM x 3 PLRU, SET_NUM x 4 valid, SET_NUM x 4 dirty); no SRAM.
// TESTING
// - Reset; read miss set 5 -> no wb_req; rf_req, rf_way=0; after rf_done: miss_done, miss_way=0, PLRU[5]=3'b110.
// - Four read misses set 5 -> ways 0,1,2,3 filled, PLRU[5]=3'b000; 5th miss picks way 0.
// - Four write misses set 7, then read miss set 7 -> wb_req way 0 first; rf_req way 0 only after wb_done.
// - Hold wb_ack low 3 cycles -> wb_req/wb_set/wb_way stable; acc_ready=0; acc_valid hits ignored (PLRU unchanged).
// - Hit way 2 on full set 5 (PLRU 000) -> PLRU 001; next miss picks way 0; hit way 0 then miss picks way 2.
// - Assert resetn low in RF_WAIT -> rf_req=0 immediately; all valid=0; acc_ready=1 after release.

Source files
------------

// File: rtl/dcache_victim_ctrl_pkg.sv
// Shared types and helpers for the 4-way data-cache replacement/refill controller.
package dcache_victim_ctrl_pkg;

  localparam int unsigned SetNum  = 64;
  localparam int unsigned SetBits = $clog2(SetNum);

  typedef logic [SetBits-1:0] set_t;
  typedef logic [1:0]         way_t;
  typedef logic [2:0]         plru_t;

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbWait,
    StRfReq,
    StRfWait,
    StDone
  } victim_state_t;

  // Lowest-index invalid way; only meaningful when at least one way is invalid.
  function automatic way_t first_invalid(input logic [3:0] valid);
    if (!valid[0])      return 2'd0;
    else if (!valid[1]) return 2'd1;
    else if (!valid[2]) return 2'd2;
    else                return 2'd3;
  endfunction

endpackage

// File: rtl/dcache_victim_ctrl_plru.sv
// Combinational 3-bit tree PLRU: victim selection and touch update for one set.
module dcache_victim_ctrl_plru
  import dcache_victim_ctrl_pkg::*;
#(
  parameter int unsigned ASSOCIATIVITY = 4
) (
  input  logic [ASSOCIATIVITY-2:0]         plru_i,
  input  logic [$clog2(ASSOCIATIVITY)-1:0] touch_way_i,
  output logic [$clog2(ASSOCIATIVITY)-1:0] victim_o,
  output logic [ASSOCIATIVITY-2:0]         plru_o
);

  always_comb begin
    victim_o = {plru_i[2], plru_i[2] ? plru_i[0] : plru_i[1]};
    plru_o    = plru_i;
    plru_o[2] = ~touch_way_i[1];
    if (touch_way_i[1]) begin
      plru_o[0] = ~touch_way_i[0];
    end else begin
      plru_o[1] = ~touch_way_i[0];
    end
  end

endmodule

// File: rtl/dcache_victim_ctrl.sv
// Per-set replacement/refill controller: owns PLRU/valid/dirty state, sequences writeback+refill.
module dcache_victim_ctrl
  import dcache_victim_ctrl_pkg::*;
#(
  parameter int unsigned ASSOCIATIVITY = 4,
  parameter int unsigned SET_NUM       = 64,
  localparam int unsigned SET_BITS     = $clog2(SET_NUM)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                acc_valid,
  input  logic [SET_BITS-1:0] acc_set,
  input  logic                acc_hit,
  input  logic [1:0]          acc_hit_way,
  input  logic                acc_write,
  output logic                acc_ready,
  output logic                miss_done,
  output logic [1:0]          miss_way,
  output logic                wb_req,
  output logic [SET_BITS-1:0] wb_set,
  output logic [1:0]          wb_way,
  input  logic                wb_ack,
  input  logic                wb_done,
  output logic                rf_req,
  output logic [SET_BITS-1:0] rf_set,
  output logic [1:0]          rf_way,
  input  logic                rf_ack,
  input  logic                rf_done
);

  victim_state_t       state_q;
  logic [SET_BITS-1:0] set_q;
  way_t                victim_q;
  logic                write_q;
  logic                acc_ready_q, miss_done_q, wb_req_q, rf_req_q;
  way_t                miss_way_q, wb_way_q, rf_way_q;
  logic [SET_BITS-1:0] wb_set_q, rf_set_q;

  plru_t                    plru_q  [SET_NUM];
  logic [ASSOCIATIVITY-1:0] valid_q [SET_NUM];
  logic [ASSOCIATIVITY-1:0] dirty_q [SET_NUM];

  logic [SET_BITS-1:0] sel_set;
  plru_t               plru_cur, plru_next;
  way_t                touch_way, plru_victim, miss_victim;
  logic                acc_fire, victim_dirty;

  // In IDLE the PLRU port serves the incoming access; otherwise the latched miss.
  always_comb begin
    acc_fire     = acc_valid && (state_q == StIdle);
    sel_set      = (state_q == StIdle) ? acc_set : set_q;
    plru_cur     = plru_q[sel_set];
    touch_way    = (state_q == StIdle) ? acc_hit_way : victim_q;
    miss_victim  = (&valid_q[acc_set]) ? plru_victim : first_invalid(valid_q[acc_set]);
    victim_dirty = valid_q[acc_set][miss_victim] && dirty_q[acc_set][miss_victim];
  end

  dcache_victim_ctrl_plru #(
    .ASSOCIATIVITY(ASSOCIATIVITY)
  ) u_plru (
    .plru_i     (plru_cur),
    .touch_way_i(touch_way),
    .victim_o   (plru_victim),
    .plru_o     (plru_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      set_q       <= '0;
      victim_q    <= '0;
      write_q     <= 1'b0;
      acc_ready_q <= 1'b1;
      miss_done_q <= 1'b0;
      miss_way_q  <= '0;
      wb_req_q    <= 1'b0;
      wb_set_q    <= '0;
      wb_way_q    <= '0;
      rf_req_q    <= 1'b0;
      rf_set_q    <= '0;
      rf_way_q    <= '0;
      for (int i = 0; i < SET_NUM; i++) begin
        plru_q[i]  <= '0;
        valid_q[i] <= '0;
        dirty_q[i] <= '0;
      end
    end else begin
      miss_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (acc_fire && acc_hit) begin
            plru_q[acc_set] <= plru_next;
            if (acc_write) dirty_q[acc_set][acc_hit_way] <= 1'b1;
          end else if (acc_fire) begin
            set_q       <= acc_set;
            write_q     <= acc_write;
            victim_q    <= miss_victim;
            acc_ready_q <= 1'b0;
            if (victim_dirty) begin
              state_q  <= StWbReq;
              wb_req_q <= 1'b1;
              wb_set_q <= acc_set;
              wb_way_q <= miss_victim;
            end else begin
              state_q  <= StRfReq;
              rf_req_q <= 1'b1;
              rf_set_q <= acc_set;
              rf_way_q <= miss_victim;
            end
          end
        end
        StWbReq: begin
          if (wb_ack) begin
            wb_req_q <= 1'b0;
            state_q  <= StWbWait;
          end
        end
        StWbWait: begin
          if (wb_done) begin
            valid_q[set_q][victim_q] <= 1'b0;
            dirty_q[set_q][victim_q] <= 1'b0;
            rf_req_q <= 1'b1;
            rf_set_q <= set_q;
            rf_way_q <= victim_q;
            state_q  <= StRfReq;
          end
        end
        StRfReq: begin
          if (rf_ack) begin
            rf_req_q <= 1'b0;
            state_q  <= StRfWait;
          end
        end
        StRfWait: begin
          if (rf_done) begin
            valid_q[set_q][victim_q] <= 1'b1;
            dirty_q[set_q][victim_q] <= write_q;
            plru_q[set_q]            <= plru_next;
            miss_done_q              <= 1'b1;
            miss_way_q               <= victim_q;
            state_q                  <= StDone;
          end
        end
        StDone: begin
          acc_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign acc_ready = acc_ready_q;
  assign miss_done = miss_done_q;
  assign miss_way  = miss_way_q;
  assign wb_req    = wb_req_q;
  assign wb_set    = wb_set_q;
  assign wb_way    = wb_way_q;
  assign rf_req    = rf_req_q;
  assign rf_set    = rf_set_q;
  assign rf_way    = rf_way_q;

endmodule

// File: tb/tb_dcache_victim_ctrl.sv
// Directed table-driven bench for dcache_victim_ctrl: hits, misses, writeback ordering, reset.
module tb_dcache_victim_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       acc_valid, acc_hit, acc_write;
  logic [5:0] acc_set;
  logic [1:0] acc_hit_way;
  logic       acc_ready, miss_done;
  logic [1:0] miss_way;
  logic       wb_req, wb_ack, wb_done;
  logic [5:0] wb_set;
  logic [1:0] wb_way;
  logic       rf_req, rf_ack, rf_done;
  logic [5:0] rf_set;
  logic [1:0] rf_way;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_victim_ctrl #(
    .ASSOCIATIVITY(4),
    .SET_NUM      (64)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .acc_valid  (acc_valid),
    .acc_set    (acc_set),
    .acc_hit    (acc_hit),
    .acc_hit_way(acc_hit_way),
    .acc_write  (acc_write),
    .acc_ready  (acc_ready),
    .miss_done  (miss_done),
    .miss_way   (miss_way),
    .wb_req     (wb_req),
    .wb_set     (wb_set),
    .wb_way     (wb_way),
    .wb_ack     (wb_ack),
    .wb_done    (wb_done),
    .rf_req     (rf_req),
    .rf_set     (rf_set),
    .rf_way     (rf_way),
    .rf_ack     (rf_ack),
    .rf_done    (rf_done)
  );

  // way: hit way for hit rows, expected victim for miss rows
  typedef struct {
    logic       hit;
    logic [5:0] set;
    logic [1:0] way;
    logic       write;
    logic       exp_wb;
    int         ack_delay;
    logic [2:0] exp_plru;
    logic [3:0] exp_dirty;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic hit, input logic [5:0] set, input logic [1:0] way,
                              input logic write, input logic exp_wb, input int ack_delay,
                              input logic [2:0] exp_plru, input logic [3:0] exp_dirty);
    vec_t v;
    v.hit = hit; v.set = set; v.way = way; v.write = write; v.exp_wb = exp_wb;
    v.ack_delay = ack_delay; v.exp_plru = exp_plru; v.exp_dirty = exp_dirty;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input vec_t v);
    check("plru", {29'd0, dut.plru_q[v.set]}, {29'd0, v.exp_plru});
    check("dirty", {28'd0, dut.dirty_q[v.set]}, {28'd0, v.exp_dirty});
  endtask

  // Entered and left on a negedge with the DUT idle.
  task automatic do_hit(input vec_t v);
    acc_valid = 1'b1; acc_hit = 1'b1; acc_set = v.set; acc_hit_way = v.way; acc_write = v.write;
    @(negedge clk);
    acc_valid = 1'b0; acc_hit = 1'b0; acc_write = 1'b0;
    check("hit_ready", {31'd0, acc_ready}, 32'd1);
    check_state(v);
  endtask

  task automatic do_miss(input vec_t v);
    check("acc_ready_idle", {31'd0, acc_ready}, 32'd1);
    acc_valid = 1'b1; acc_hit = 1'b0; acc_set = v.set; acc_write = v.write;
    @(negedge clk);
    acc_valid = 1'b0; acc_write = 1'b0;
    check("acc_ready_busy", {31'd0, acc_ready}, 32'd0);
    if (v.exp_wb) begin
      check("wb_req", {31'd0, wb_req}, 32'd1);
      check("wb_set", {26'd0, wb_set}, {26'd0, v.set});
      check("wb_way", {30'd0, wb_way}, {30'd0, v.way});
      check("rf_req_before_wb", {31'd0, rf_req}, 32'd0);
      for (int k = 0; k < v.ack_delay; k++) begin
        // Hits offered while busy must be ignored.
        acc_valid = 1'b1; acc_hit = 1'b1; acc_hit_way = 2'd2; acc_write = 1'b1; acc_set = v.set;
        @(negedge clk);
        check("wb_req_hold", {31'd0, wb_req}, 32'd1);
        check("wb_set_hold", {26'd0, wb_set}, {26'd0, v.set});
        check("wb_way_hold", {30'd0, wb_way}, {30'd0, v.way});
        check("acc_ready_stall", {31'd0, acc_ready}, 32'd0);
      end
      acc_valid = 1'b0; acc_hit = 1'b0; acc_write = 1'b0;
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      check("wb_req_drop", {31'd0, wb_req}, 32'd0);
      @(negedge clk);
      check("rf_req_wb_wait", {31'd0, rf_req}, 32'd0);
      wb_done = 1'b1;
      @(negedge clk);
      wb_done = 1'b0;
    end else begin
      check("no_wb_req", {31'd0, wb_req}, 32'd0);
    end
    check("rf_req", {31'd0, rf_req}, 32'd1);
    check("rf_set", {26'd0, rf_set}, {26'd0, v.set});
    check("rf_way", {30'd0, rf_way}, {30'd0, v.way});
    rf_ack = 1'b1;
    @(negedge clk);
    rf_ack = 1'b0;
    check("rf_req_drop", {31'd0, rf_req}, 32'd0);
    rf_done = 1'b1;
    @(negedge clk);
    rf_done = 1'b0;
    check("miss_done", {31'd0, miss_done}, 32'd1);
    check("miss_way", {30'd0, miss_way}, {30'd0, v.way});
    check("acc_ready_done", {31'd0, acc_ready}, 32'd0);
    @(negedge clk);
    check("miss_done_pulse", {31'd0, miss_done}, 32'd0);
    check("acc_ready_back", {31'd0, acc_ready}, 32'd1);
    check_state(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(0, 5,  0, 0, 0, 0, 3'b110, 4'b0000);
    vecs[1]  = mk(0, 5,  1, 0, 0, 0, 3'b100, 4'b0000);
    vecs[2]  = mk(0, 5,  2, 0, 0, 0, 3'b001, 4'b0000);
    vecs[3]  = mk(0, 5,  3, 0, 0, 0, 3'b000, 4'b0000);
    vecs[4]  = mk(0, 5,  0, 0, 0, 0, 3'b110, 4'b0000);
    vecs[5]  = mk(0, 7,  0, 1, 0, 0, 3'b110, 4'b0001);
    vecs[6]  = mk(0, 7,  1, 1, 0, 0, 3'b100, 4'b0011);
    vecs[7]  = mk(0, 7,  2, 1, 0, 0, 3'b001, 4'b0111);
    vecs[8]  = mk(0, 7,  3, 1, 0, 0, 3'b000, 4'b1111);
    vecs[9]  = mk(0, 7,  0, 0, 1, 3, 3'b110, 4'b1110);
    vecs[10] = mk(0, 11, 0, 0, 0, 0, 3'b110, 4'b0000);
    vecs[11] = mk(0, 11, 1, 0, 0, 0, 3'b100, 4'b0000);
    vecs[12] = mk(0, 11, 2, 0, 0, 0, 3'b001, 4'b0000);
    vecs[13] = mk(0, 11, 3, 0, 0, 0, 3'b000, 4'b0000);
    vecs[14] = mk(1, 11, 2, 0, 0, 0, 3'b001, 4'b0000);
    vecs[15] = mk(0, 11, 0, 0, 0, 0, 3'b111, 4'b0000);
    vecs[16] = mk(0, 9,  0, 0, 0, 0, 3'b110, 4'b0000);
    vecs[17] = mk(0, 9,  1, 0, 0, 0, 3'b100, 4'b0000);
    vecs[18] = mk(0, 9,  2, 0, 0, 0, 3'b001, 4'b0000);
    vecs[19] = mk(0, 9,  3, 0, 0, 0, 3'b000, 4'b0000);
    vecs[20] = mk(1, 9,  0, 1, 0, 0, 3'b110, 4'b0001);
    vecs[21] = mk(0, 9,  2, 0, 0, 0, 3'b011, 4'b0001);
    vecs[22] = mk(1, 9,  1, 0, 0, 0, 3'b101, 4'b0001);
    vecs[23] = mk(0, 9,  3, 0, 0, 0, 3'b000, 4'b0001);
    vecs[24] = mk(0, 9,  0, 0, 1, 0, 3'b110, 4'b0000);

    resetn = 1'b0;
    acc_valid = 1'b0; acc_hit = 1'b0; acc_write = 1'b0; acc_set = '0; acc_hit_way = '0;
    wb_ack = 1'b0; wb_done = 1'b0; rf_ack = 1'b0; rf_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_acc_ready", {31'd0, acc_ready}, 32'd1);
    check("rst_wb_req", {31'd0, wb_req}, 32'd0);
    check("rst_rf_req", {31'd0, rf_req}, 32'd0);
    check("rst_miss_done", {31'd0, miss_done}, 32'd0);
    check("rst_outs", {16'd0, wb_set, wb_way, rf_set, rf_way}, 32'd0);
    check("rst_miss_way", {30'd0, miss_way}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Consecutive rows run back to back, so a hit row followed by a miss row
    // exercises a miss in the cycle right after a hit to the same set.
    for (int i = 0; i < 25; i++) begin
      if (vecs[i].hit) do_hit(vecs[i]);
      else             do_miss(vecs[i]);
    end

    // Reset while the refill is outstanding.
    acc_valid = 1'b1; acc_hit = 1'b0; acc_set = 6'd20; acc_write = 1'b1;
    @(negedge clk);
    acc_valid = 1'b0; acc_write = 1'b0;
    check("rst_mid_rf_req", {31'd0, rf_req}, 32'd1);
    rf_ack = 1'b1;
    @(negedge clk);
    rf_ack = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("async_rf_req_drop", {31'd0, rf_req}, 32'd0);
    check("async_acc_ready", {31'd0, acc_ready}, 32'd1);
    check("async_valid5", {28'd0, dut.valid_q[5]}, 32'd0);
    check("async_valid9", {28'd0, dut.valid_q[9]}, 32'd0);
    check("async_plru7", {29'd0, dut.plru_q[7]}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    rf_done = 1'b1;
    @(negedge clk);
    rf_done = 1'b0;
    check("post_rst_ready", {31'd0, acc_ready}, 32'd1);
    check("post_rst_miss_done", {31'd0, miss_done}, 32'd0);
    check("post_rst_valid20", {28'd0, dut.valid_q[20]}, 32'd0);
    do_miss(mk(0, 5, 0, 0, 0, 0, 3'b110, 4'b0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
